// File: rtl/seq_gen_pkg.sv
// Shared definitions for the 1011 sync-framed serial link (transmit side).
package seq_gen_pkg;

    // Frame phases of the serial transmitter.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_DATA  = 2'd2,
        ST_GUARD = 2'd3
    } seq_state_e;

    // Sync pattern shared with the detector side of the link.
    localparam int                    SEQ_SYNC_W    = 4;
    localparam logic [SEQ_SYNC_W-1:0] SEQ_SYNC_PAT  = 4'b1011;
    localparam int                    SEQ_DATA_W    = 8;
    localparam int                    SEQ_GUARD_CYC = 2;

    // Total line cycles occupied by one frame.
    function automatic int frame_len(int sync_w, int data_w, int guard_cyc);
        return sync_w + data_w + guard_cyc;
    endfunction

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_gen_tx.sv
// Serial frame transmitter: sync pattern, payload MSB first, then low guard bits.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line low, ready for a word
// ST_SYNC  | sending sync pattern, MSB first, cnt = bit index
// ST_DATA  | sending latched payload MSB first, shreg shifts left
// ST_GUARD | line low; last guard cycle pulses done and accepts next word
module seq_gen_tx
    import seq_gen_pkg::*;
#(
    parameter int                SYNC_W    = SEQ_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PAT  = SEQ_SYNC_PAT,
    parameter int                DATA_W    = SEQ_DATA_W,
    parameter int                GUARD_CYC = SEQ_GUARD_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              sout,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(max3(SYNC_W, DATA_W, GUARD_CYC) + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  SYNC_LAST  = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [SYNC_W-1:0] SYNC_MSB   = SYNC_W'(1) << (SYNC_W - 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              sout_q, sout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              guard_last;
    logic              accept;
    logic [SYNC_W-1:0] sync_sh;

    // Ready depends only on flops so the sender never sees a valid->ready path.
    assign guard_last = (state_q == ST_GUARD) && (cnt_q == GUARD_LAST);
    assign in_ready   = (state_q == ST_IDLE) || guard_last;

    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

    // State, counter, payload and registered line outputs; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Frame sequencing: count through each phase, chain frames on the last guard bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        accept  = in_valid & in_ready;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SYNC;
                    cnt_d   = '0;
                    shreg_d = in_data;
                end
            end
            ST_SYNC: begin
                if (cnt_q == SYNC_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                shreg_d = shreg_q << 1;
                if (cnt_q == DATA_LAST) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    cnt_d = '0;
                    if (accept) begin
                        state_d = ST_SYNC;
                        shreg_d = in_data;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Line outputs are derived from the next state so they appear as flop outputs
    // in the same cycle the FSM enters that phase.
    always_comb begin
        sync_sh = SYNC_PAT << cnt_d;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_GUARD) && (cnt_d == GUARD_LAST);
        sout_d  = 1'b0;
        case (state_d)
            ST_SYNC: sout_d = |(sync_sh & SYNC_MSB);
            ST_DATA: sout_d = shreg_d[DATA_W-1];
            default: sout_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_seq_gen_tx.sv
// Bench for seq_gen_tx: default instance plus a small-parameter instance,
// both tracked by a frame-position reference model.
module tb_seq_gen_tx;

    localparam int F0 = 14;
    localparam int F1 = 9;

    logic       clk;
    logic       rst;
    logic       in_valid, in_ready0, sout0, busy0, done0;
    logic [7:0] in_data;
    logic       in_valid1, in_ready1, sout1, busy1, done1;
    logic [4:0] in_data1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: position within the frame (0 = idle, 1..F = line cycle).
    int         m0_pos = 0;
    int         m0_word = 0;
    int         m1_pos = 0;
    int         m1_word = 0;
    logic [7:0] acc_q[$];
    logic [7:0] rx_q[$];
    logic [13:0] rx_hist = '0;
    logic [3:0]  det_hist = '0;
    int          det_cnt = 0;

    seq_gen_tx u_dut0 (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready0),
        .in_data (in_data),
        .sout    (sout0),
        .busy    (busy0),
        .done    (done0)
    );

    seq_gen_tx #(
        .SYNC_W   (3),
        .SYNC_PAT (3'b101),
        .DATA_W   (5),
        .GUARD_CYC(1)
    ) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid1),
        .in_ready(in_ready1),
        .in_data (in_data1),
        .sout    (sout1),
        .busy    (busy1),
        .done    (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Bit on the line at frame position p for a given frame layout.
    function automatic logic exp_bit(int p, int sw, int pat, int dw, int word);
        if (p >= 1 && p <= sw)           return pat[sw - p];
        else if (p > sw && p <= sw + dw) return word[dw - 1 - (p - sw - 1)];
        else                             return 1'b0;
    endfunction

    // One clock: advance the model on the edge, then compare both instances.
    task automatic tick();
        logic rdy0, rdy1;
        @(posedge clk);
        if (rst) begin
            m0_pos = 0;
            m1_pos = 0;
        end else begin
            rdy0 = (m0_pos == 0) || (m0_pos == F0);
            if (in_valid && rdy0) begin
                m0_pos  = 1;
                m0_word = int'(in_data);
                acc_q.push_back(in_data);
            end else if (rdy0) m0_pos = 0;
            else               m0_pos++;
            rdy1 = (m1_pos == 0) || (m1_pos == F1);
            if (in_valid1 && rdy1) begin
                m1_pos  = 1;
                m1_word = int'(in_data1);
            end else if (rdy1) m1_pos = 0;
            else               m1_pos++;
        end
        cyc++;
        #1;
        checks += 8;
        if (sout0 !== exp_bit(m0_pos, 4, 'b1011, 8, m0_word)) begin
            errors++;
            $display("FAIL sout0 cyc=%0d pos=%0d got=%b exp=%b", cyc, m0_pos, sout0, exp_bit(m0_pos, 4, 'b1011, 8, m0_word));
        end
        if (busy0 !== (m0_pos != 0)) begin
            errors++;
            $display("FAIL busy0 cyc=%0d got=%b exp=%b", cyc, busy0, m0_pos != 0);
        end
        if (done0 !== (m0_pos == F0)) begin
            errors++;
            $display("FAIL done0 cyc=%0d got=%b exp=%b", cyc, done0, m0_pos == F0);
        end
        if (in_ready0 !== (m0_pos == 0 || m0_pos == F0)) begin
            errors++;
            $display("FAIL in_ready0 cyc=%0d got=%b exp=%b", cyc, in_ready0, (m0_pos == 0 || m0_pos == F0));
        end
        if (sout1 !== exp_bit(m1_pos, 3, 'b101, 5, m1_word)) begin
            errors++;
            $display("FAIL sout1 cyc=%0d pos=%0d got=%b exp=%b", cyc, m1_pos, sout1, exp_bit(m1_pos, 3, 'b101, 5, m1_word));
        end
        if (busy1 !== (m1_pos != 0)) begin
            errors++;
            $display("FAIL busy1 cyc=%0d got=%b exp=%b", cyc, busy1, m1_pos != 0);
        end
        if (done1 !== (m1_pos == F1)) begin
            errors++;
            $display("FAIL done1 cyc=%0d got=%b exp=%b", cyc, done1, m1_pos == F1);
        end
        if (in_ready1 !== (m1_pos == 0 || m1_pos == F1)) begin
            errors++;
            $display("FAIL in_ready1 cyc=%0d got=%b exp=%b", cyc, in_ready1, (m1_pos == 0 || m1_pos == F1));
        end
        rx_hist  = {rx_hist[12:0], sout0};
        det_hist = {det_hist[2:0], sout0};
        if (det_hist == 4'b1011) det_cnt++;
        if (done0 === 1'b1) rx_q.push_back(rx_hist[9:2]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({sout0, busy0, done0} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=000", {sout0, busy0, done0});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({in_ready0, in_ready1} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=11", {in_ready0, in_ready1});
        end
    endtask

    task automatic test_single();
        logic [13:0] exp_line;
        exp_line = 14'b1011_10100101_00;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            if (i > 1) begin
                in_data = 8'($urandom);
                tick();
            end
            checks++;
            if (sout0 !== exp_line[14 - i] || done0 !== (i == 14) || busy0 !== 1'b1) begin
                errors++;
                $display("FAIL single_frame i=%0d got sout/done/busy=%b%b%b exp=%b%b1",
                         i, sout0, done0, busy0, exp_line[14 - i], (i == 14));
            end
        end
        tick();
        checks++;
        if (busy0 !== 1'b0 || rx_q.size() == 0 || rx_q[$] !== 8'hA5) begin
            errors++;
            $display("FAIL single_payload busy=%b rx_n=%0d exp busy=0 payload=a5", busy0, rx_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int busy_low;
        int det0;
        busy_low = 0;
        det0     = det_cnt;
        rx_q.delete();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        in_data = 8'h00;
        for (int i = 2; i <= 14; i++) begin
            tick();
            if (busy0 !== 1'b1) busy_low++;
        end
        checks++;
        if (in_ready0 !== 1'b1 || done0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_at_F got ready=%b done=%b exp=1 1", in_ready0, done0);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (sout0 !== 1'b1 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_sync got sout=%b busy=%b exp=1 1", sout0, busy0);
        end
        for (int i = 2; i <= 14; i++) begin
            tick();
            if (busy0 !== 1'b1) busy_low++;
        end
        tick();
        checks++;
        if (busy_low != 0) begin
            errors++;
            $display("FAIL b2b_busy_gap got=%0d low cycles exp=0", busy_low);
        end
        checks++;
        if (det_cnt - det0 != 2) begin
            errors++;
            $display("FAIL b2b_detect got=%0d exp=2", det_cnt - det0);
        end
        checks++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'hFF || rx_q[1] !== 8'h00) begin
            errors++;
            $display("FAIL b2b_payloads got n=%0d exp=2 frames ff,00", rx_q.size());
        end
    endtask

    task automatic test_backpressure();
        int t0, acc_at, n3c;
        rx_q.delete();
        in_valid = 1'b1;
        in_data  = 8'($urandom_range(0, 255));
        tick();
        t0       = cyc;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b1;
        in_data  = 8'h3C;
        acc_at   = -1;
        for (int i = 0; i < 40 && acc_at < 0; i++) begin
            if (in_ready0 === 1'b1) acc_at = cyc + 1 - t0;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (acc_at != 14) begin
            errors++;
            $display("FAIL bp_accept_edge got=%0d exp=14", acc_at);
        end
        for (int i = 0; i < 16; i++) tick();
        n3c = 0;
        foreach (rx_q[k]) if (rx_q[k] === 8'h3C) n3c++;
        checks++;
        if (n3c != 1 || rx_q.size() != 2) begin
            errors++;
            $display("FAIL bp_once got 3c_count=%0d frames=%0d exp=1 2", n3c, rx_q.size());
        end
    endtask

    task automatic test_stability();
        in_valid = 1'b1;
        in_data  = 8'h81;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            in_data = 8'($urandom);
            tick();
        end
        checks++;
        if (rx_q.size() == 0 || rx_q[$] !== 8'h81) begin
            errors++;
            $display("FAIL stability got=%h exp=81", (rx_q.size() == 0) ? 8'hxx : rx_q[$]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        int         done_seen;
        done_seen = 0;
        in_valid  = 1'b1;
        in_data   = 8'($urandom);
        tick();
        in_valid = 1'b0;
        for (int i = 2; i <= 7; i++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({sout0, busy0, done0} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_outputs got=%b exp=000", {sout0, busy0, done0});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready got=%b exp=1", in_ready0);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done0 === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL rstmid_done got=%0d pulses exp=0", done_seen);
        end
        w        = 8'($urandom);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (rx_q.size() == 0 || rx_q[$] !== w) begin
            errors++;
            $display("FAIL rstmid_refrm got=%h exp=%h", (rx_q.size() == 0) ? 8'hxx : rx_q[$], w);
        end
    endtask

    task automatic test_sweep();
        logic [8:0] exp_line;
        exp_line  = 9'b101_10110_0;
        in_valid1 = 1'b1;
        in_data1  = 5'b10110;
        tick();
        in_valid1 = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i > 1) tick();
            checks++;
            if (sout1 !== exp_line[9 - i] || done1 !== (i == 9) || in_ready1 !== (i == 9)) begin
                errors++;
                $display("FAIL sweep i=%0d got sout/done/ready=%b%b%b exp=%b%b%b",
                         i, sout1, done1, in_ready1, exp_line[9 - i], (i == 9), (i == 9));
            end
        end
        tick();
    endtask

    task automatic test_random();
        logic rdy0, rdy1;
        acc_q.delete();
        rx_q.delete();
        for (int i = 0; i < 400; i++) begin
            rdy0 = in_ready0;
            rdy1 = in_ready1;
            tick();
            if (!in_valid || rdy0) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 8'($urandom);
            end
            if (!in_valid1 || rdy1) begin
                in_valid1 = ($urandom_range(0, 2) != 0);
                in_data1  = 5'($urandom);
            end
        end
        in_valid  = 1'b0;
        in_valid1 = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (rx_q.size() != acc_q.size() || rx_q.size() < 10) begin
            errors++;
            $display("FAIL random_count got=%0d frames exp=%0d", rx_q.size(), acc_q.size());
        end else begin
            foreach (acc_q[k]) begin
                checks++;
                if (rx_q[k] !== acc_q[k]) begin
                    errors++;
                    $display("FAIL random_payload k=%0d got=%h exp=%h", k, rx_q[k], acc_q[k]);
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_valid1 = 1'b0;
        in_data1  = 5'h00;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_stability();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
